// File: rtl/cpu_pkg.sv
// Shared CPU constants and types.
// Used by the decoder, register file and multiplier.
package cpu_pkg;

  localparam int DATA_W     = 8;
  localparam int REG_ADDR_W = 3;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_WB   = 2'd2
  } mul_state_e;

  localparam logic [3:0] OP_MUL = 4'b1010;

endpackage

// File: rtl/mul_datapath.sv
// Shift-add datapath: accumulator, shifted multiplicand
// and multiplier, plus the partial-product adder.
module mul_datapath
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic [2*WIDTH-1:0] acc_nxt
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;

  assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Load operands on accept, otherwise consume one multiplier bit per step.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (load) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, op_a};
      mplier_d = op_b;
    end else if (step) begin
      acc_d    = acc_nxt;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/mul_unit.sv
// Multi-cycle unsigned shift-add multiplier feeding the
// register file write port with a one-cycle WRITE strobe.
module mul_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH  = DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [WIDTH-1:0]  OPERAND1,
  input  logic [WIDTH-1:0]  OPERAND2,
  input  logic [ADDR_W-1:0] DESTADDR,
  output logic [WIDTH-1:0]  RESULT,
  output logic [ADDR_W-1:0] WRITEADDR,
  output logic              WRITE,
  output logic              BUSY,
  output logic              OVERFLOW
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mul_state_e         state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [ADDR_W-1:0]  dest_q, dest_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic               ovf_q, ovf_d;
  logic               write_q, write_d;
  logic               busy_q, busy_d;
  logic               load, step;
  logic [2*WIDTH-1:0] acc_nxt;

  mul_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk     (CLK),
    .rst_n   (RESET),
    .load    (load),
    .step    (step),
    .op_a    (OPERAND1),
    .op_b    (OPERAND2),
    .acc_nxt (acc_nxt)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    dest_d   = dest_q;
    result_d = result_q;
    waddr_d  = waddr_q;
    ovf_d    = ovf_q;
    write_d  = 1'b0;
    busy_d   = 1'b0;
    load     = 1'b0;
    step     = 1'b0;
    unique case (state_q)
      MUL_IDLE: begin
        if (START) begin
          load    = 1'b1;
          count_d = '0;
          dest_d  = DESTADDR;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = MUL_RUN;
        end
      end
      MUL_RUN: begin
        step    = 1'b1;
        busy_d  = 1'b1;
        count_d = count_q + 1'b1;
        if (count_q == LAST) begin
          state_d  = MUL_WB;
          write_d  = 1'b1;
          result_d = acc_nxt[WIDTH-1:0];
          waddr_d  = dest_q;
          ovf_d    = |acc_nxt[2*WIDTH-1:WIDTH];
        end
      end
      MUL_WB: begin
        state_d = MUL_IDLE;
      end
      default: begin
        state_d = MUL_IDLE;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= MUL_IDLE;
      count_q  <= '0;
      dest_q   <= '0;
      result_q <= '0;
      waddr_q  <= '0;
      ovf_q    <= 1'b0;
      write_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      dest_q   <= dest_d;
      result_q <= result_d;
      waddr_q  <= waddr_d;
      ovf_q    <= ovf_d;
      write_q  <= write_d;
      busy_q   <= busy_d;
    end
  end

  assign RESULT    = result_q;
  assign WRITEADDR = waddr_q;
  assign WRITE     = write_q;
  assign BUSY      = busy_q;
  assign OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit with a register
// file model hooked to its write port.
module tb_mul_unit;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       START;
  logic [7:0] OPERAND1;
  logic [7:0] OPERAND2;
  logic [2:0] DESTADDR;
  logic [7:0] RESULT;
  logic [2:0] WRITEADDR;
  logic       WRITE;
  logic       BUSY;
  logic       OVERFLOW;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] rf [8] = '{8'h11, 8'h22, 8'h33, 8'h44,
                         8'h55, 8'h66, 8'h77, 8'h88};
  logic [7:0] exp_rf [8];

  mul_unit dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START     (START),
    .OPERAND1  (OPERAND1),
    .OPERAND2  (OPERAND2),
    .DESTADDR  (DESTADDR),
    .RESULT    (RESULT),
    .WRITEADDR (WRITEADDR),
    .WRITE     (WRITE),
    .BUSY      (BUSY),
    .OVERFLOW  (OVERFLOW)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (WRITE === 1'b1) rf[WRITEADDR] <= RESULT;
  end

  function automatic logic [15:0] prod(input logic [7:0] a, input logic [7:0] b);
    return 16'(a) * 16'(b);
  endfunction

  // Drives one operation from IDLE (called at posedge+1) and
  // observes 12 cycles after the accepting edge.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] d,
                        output int lat, output int nw,
                        output logic [7:0] res, output logic [2:0] wa,
                        output logic ovf, output int busy_bad);
    START = 1'b1; OPERAND1 = a; OPERAND2 = b; DESTADDR = d;
    @(posedge CLK); #1;
    lat = -1; nw = 0; busy_bad = 0;
    res = '0; wa = '0; ovf = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (BUSY !== (k <= 8)) busy_bad++;
      if (WRITE === 1'b1) begin
        nw++; lat = k; res = RESULT; wa = WRITEADDR; ovf = OVERFLOW;
      end
      OPERAND1 = 8'($urandom);
      OPERAND2 = 8'($urandom);
      DESTADDR = 3'($urandom);
      START = (k <= 8) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_reset;
    RESET = 1'b0; START = 1'b0;
    OPERAND1 = '0; OPERAND2 = '0; DESTADDR = '0;
    #1;
    n_cmp++;
    if ({RESULT, WRITEADDR, WRITE, BUSY, OVERFLOW} !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_async: got %h/%h/%b/%b/%b need all 0",
               RESULT, WRITEADDR, WRITE, BUSY, OVERFLOW);
    end
    @(posedge CLK); #1;
    n_cmp++;
    if ({RESULT, WRITEADDR, WRITE, BUSY, OVERFLOW} !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_clocked: got %h/%h/%b/%b/%b need all 0",
               RESULT, WRITEADDR, WRITE, BUSY, OVERFLOW);
    end
    RESET = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_directed;
    logic [7:0] ta [4] = '{8'd3, 8'd16, 8'd255, 8'd0};
    logic [7:0] tb [4] = '{8'd5, 8'd16, 8'd255, 8'd200};
    logic [2:0] td [4] = '{3'd2, 3'd6, 3'd1, 3'd3};
    logic [7:0] er [4] = '{8'h0F, 8'h00, 8'h01, 8'h00};
    logic       eo [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int lat, nw, bb;
    logic [7:0] res;
    logic [2:0] wa;
    logic ovf;
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tb[i], td[i], lat, nw, res, wa, ovf, bb);
      exp_rf[td[i]] = er[i];
      n_cmp++;
      if (nw != 1 || lat != 8) begin
        n_bad++;
        $display("FAIL dir%0d_write: got %0d writes at %0d need 1 at 8", i, nw, lat);
      end
      n_cmp++;
      if (res !== er[i] || ovf !== eo[i]) begin
        n_bad++;
        $display("FAIL dir%0d_result: got %h ovf %b need %h ovf %b",
                 i, res, ovf, er[i], eo[i]);
      end
      n_cmp++;
      if (wa !== td[i]) begin
        n_bad++;
        $display("FAIL dir%0d_addr: got %0d need %0d", i, wa, td[i]);
      end
      n_cmp++;
      if (bb != 0) begin
        n_bad++;
        $display("FAIL dir%0d_busy: got %0d bad cycles need 0", i, bb);
      end
    end
  endtask

  task automatic test_random;
    int lat, nw, bb;
    logic [7:0] res, a, b;
    logic [2:0] wa, d;
    logic ovf;
    logic [15:0] p;
    for (int i = 0; i < 10; i++) begin
      a = 8'($urandom); b = 8'($urandom); d = 3'($urandom);
      p = prod(a, b);
      run_op(a, b, d, lat, nw, res, wa, ovf, bb);
      exp_rf[d] = p[7:0];
      n_cmp++;
      if (nw != 1 || lat != 8 || bb != 0) begin
        n_bad++;
        $display("FAIL rnd%0d_timing: got %0d writes at %0d busybad %0d need 1 at 8 busybad 0",
                 i, nw, lat, bb);
      end
      n_cmp++;
      if (res !== p[7:0] || ovf !== (p > 16'd255) || wa !== d) begin
        n_bad++;
        $display("FAIL rnd%0d_value: %0d*%0d got %h ovf %b addr %0d need %h ovf %b addr %0d",
                 i, a, b, res, ovf, wa, p[7:0], (p > 16'd255), d);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] ah [41];
    logic [7:0] bh [41];
    logic [2:0] dh [41];
    logic [15:0] p;
    logic ew;
    int nw = 0;
    for (int n = 0; n < 41; n++) begin
      ah[n] = 8'($urandom); bh[n] = 8'($urandom); dh[n] = 3'($urandom);
      START = (n <= 30); OPERAND1 = ah[n]; OPERAND2 = bh[n]; DESTADDR = dh[n];
      @(posedge CLK); #1;
      ew = (n % 10 == 8);
      if (WRITE === 1'b1) nw++;
      n_cmp++;
      if (WRITE !== ew) begin
        n_bad++;
        $display("FAIL b2b_write_e%0d: got %b need %b", n, WRITE, ew);
      end
      if (ew) begin
        p = prod(ah[n-8], bh[n-8]);
        exp_rf[dh[n-8]] = p[7:0];
        n_cmp++;
        if (RESULT !== p[7:0] || OVERFLOW !== (p > 16'd255) || WRITEADDR !== dh[n-8]) begin
          n_bad++;
          $display("FAIL b2b_value_e%0d: got %h ovf %b addr %0d need %h ovf %b addr %0d",
                   n, RESULT, OVERFLOW, WRITEADDR, p[7:0], (p > 16'd255), dh[n-8]);
        end
      end
    end
    n_cmp++;
    if (nw != 4) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d writes need 4", nw);
    end
    START = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset_mid_run;
    int lat, nw, bb;
    logic [7:0] res;
    logic [2:0] wa;
    logic ovf;
    logic [15:0] p;
    START = 1'b1; OPERAND1 = 8'd77; OPERAND2 = 8'd13; DESTADDR = 3'd4;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (4) @(posedge CLK);
    #3;
    RESET = 1'b0;
    #1;
    n_cmp++;
    if ({RESULT, WRITEADDR, WRITE, BUSY, OVERFLOW} !== 15'd0) begin
      n_bad++;
      $display("FAIL midrun_reset: got %h/%h/%b/%b/%b need all 0",
               RESULT, WRITEADDR, WRITE, BUSY, OVERFLOW);
    end
    @(posedge CLK); #1;
    RESET = 1'b1;
    nw = 0;
    for (int k = 0; k < 12; k++) begin
      if (WRITE !== 1'b0 || BUSY !== 1'b0) nw++;
      @(posedge CLK); #1;
    end
    n_cmp++;
    if (nw != 0) begin
      n_bad++;
      $display("FAIL midrun_nowrite: got %0d active cycles need 0", nw);
    end
    p = prod(8'd77, 8'd13);
    run_op(8'd77, 8'd13, 3'd4, lat, nw, res, wa, ovf, bb);
    exp_rf[4] = p[7:0];
    n_cmp++;
    if (nw != 1 || lat != 8 || res !== p[7:0] || ovf !== 1'b1 || wa !== 3'd4) begin
      n_bad++;
      $display("FAIL midrun_after: got %0d writes at %0d res %h ovf %b addr %0d need 1 at 8 res %h ovf 1 addr 4",
               nw, lat, res, ovf, wa, p[7:0]);
    end
  endtask

  task automatic test_hookup;
    int lat, nw, bb;
    logic [7:0] res;
    logic [2:0] wa;
    logic ovf;
    run_op(8'd7, 8'd9, 3'd5, lat, nw, res, wa, ovf, bb);
    exp_rf[5] = 8'h3F;
    @(posedge CLK); #1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (rf[i] !== exp_rf[i]) begin
        n_bad++;
        $display("FAIL rf_reg%0d: got %h need %h", i, rf[i], exp_rf[i]);
      end
    end
  endtask

  initial begin
    exp_rf = '{8'h11, 8'h22, 8'h33, 8'h44,
               8'h55, 8'h66, 8'h77, 8'h88};
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    test_hookup();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
